// File: rtl/sl_tx_fifo.sv
// SL-line word transmitter with input FIFO, programmable word length, phase divider and parity.
// Define SL_TX_PARITY_SEL_EN to make parity selectable; otherwise parity is fixed odd.
module sl_tx_fifo #(
    parameter int MAX_BITS   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(MAX_BITS + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [MAX_BITS-1:0]             wr_data,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [CNT_W-1:0]                cfg_bits,
    input  logic [2:0]                      cfg_div,
    input  logic                            cfg_parity_even,
    input  logic                            cfg_we,
    output logic                            cfg_err,
    output logic                            sl0,
    output logic                            sl1,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            word_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [6:0] {
        S_IDLE     = 7'b0000001,
        S_LEAD     = 7'b0000010,
        S_DATA     = 7'b0000100,
        S_BIT_END  = 7'b0001000,
        S_PAR      = 7'b0010000,
        S_STOP     = 7'b0100000,
        S_WORD_END = 7'b1000000
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]    bit_idx_q, bit_idx_d;
    logic                par_done_q, par_done_d;
    logic                par_bit_q, par_bit_d;
    logic [MAX_BITS-1:0] data_q, data_d;
    logic [CNT_W-1:0]    sh_bits_q, sh_bits_d;
    logic [2:0]          sh_div_q, sh_div_d;
    logic [CNT_W-1:0]    cfg_bits_q, cfg_bits_d;
    logic [2:0]          cfg_div_q, cfg_div_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    count_q, count_d;
    logic [MAX_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                sl0_q, sl0_d, sl1_q, sl1_d;
    logic                busy_q, busy_d, wr_ready_q, wr_ready_d;
    logic                word_done_q, word_done_d, cfg_err_q, cfg_err_d;

    logic                push, start, phase_end, fifo_nonempty, cfg_legal;
    logic                par_even, head_x;
    logic [4:0]          plast;
    logic [MAX_BITS-1:0] head;

    // Configuration register: illegal writes leave it untouched and only raise cfg_err.
    always_comb begin
        cfg_legal = ~cfg_bits[0] && (cfg_bits >= CNT_W'(8)) &&
                    (cfg_bits <= CNT_W'(MAX_BITS)) && (cfg_div <= 3'd4);
        cfg_bits_d = cfg_bits_q;
        cfg_div_d  = cfg_div_q;
        if (cfg_we && cfg_legal) begin
            cfg_bits_d = cfg_bits;
            cfg_div_d  = cfg_div;
        end
        cfg_err_d = cfg_we && !cfg_legal;
    end

`ifdef SL_TX_PARITY_SEL_EN
    logic par_even_q, par_even_d;

    always_comb begin
        par_even_d = par_even_q;
        if (cfg_we && cfg_legal) par_even_d = cfg_parity_even;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) par_even_q <= 1'b0;
        else        par_even_q <= par_even_d;
    end

    assign par_even = par_even_q;
`else
    logic unused_parity_even;
    assign unused_parity_even = cfg_parity_even;
    assign par_even = 1'b0;
`endif

    // Parity of the head word is taken over the configured bit count at pop time.
    always_comb begin
        head   = mem_q[rd_ptr_q];
        head_x = 1'b0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < int'(cfg_bits_q)) head_x = head_x ^ head[i];
        end
    end

    assign fifo_nonempty = (count_q != '0);
    assign plast         = 5'((6'd2 << sh_div_q) - 6'd1);
    assign phase_end     = (cnt_q == plast);

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        data_d      = data_q;
        bit_idx_d   = bit_idx_q;
        par_done_d  = par_done_q;
        par_bit_d   = par_bit_q;
        sh_bits_d   = sh_bits_q;
        sh_div_d    = sh_div_q;
        word_done_d = 1'b0;
        case (state_q)
            S_IDLE:  if (fifo_nonempty) start = 1'b1;
            S_LEAD:  if (phase_end) state_d = S_DATA;
            S_DATA: begin
                if (phase_end) begin
                    state_d   = S_BIT_END;
                    data_d    = data_q >> 1;
                    bit_idx_d = bit_idx_q + CNT_W'(1);
                end
            end
            S_BIT_END: begin
                if (phase_end) begin
                    if (par_done_q)                  state_d = S_STOP;
                    else if (bit_idx_q < sh_bits_q)  state_d = S_DATA;
                    else                             state_d = S_PAR;
                end
            end
            S_PAR: begin
                if (phase_end) begin
                    state_d    = S_BIT_END;
                    par_done_d = 1'b1;
                end
            end
            S_STOP:  if (phase_end) state_d = S_WORD_END;
            S_WORD_END: begin
                if (phase_end) begin
                    word_done_d = 1'b1;
                    if (fifo_nonempty) start = 1'b1;
                    else               state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d    = S_LEAD;
            data_d     = head;
            bit_idx_d  = '0;
            par_done_d = 1'b0;
            par_bit_d  = par_even ? head_x : ~head_x;
            sh_bits_d  = cfg_bits_q;
            sh_div_d   = cfg_div_q;
        end
        cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? 5'd0 : cnt_q + 5'd1;

        // Lines are registered from the next state so they switch with the state.
        case (state_d)
            S_DATA:  {sl0_d, sl1_d} = {data_d[0], ~data_d[0]};
            S_PAR:   {sl0_d, sl1_d} = {par_bit_d, ~par_bit_d};
            S_STOP:  {sl0_d, sl1_d} = 2'b00;
            default: {sl0_d, sl1_d} = 2'b11;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // wr_ready reflects occupancy before this cycle's pop, so a full FIFO never accepts.
    always_comb begin
        push     = wr_valid && wr_ready_q;
        wr_ptr_d = push  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = start ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, start})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
        wr_ready_d = (count_d != LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            par_done_q  <= 1'b0;
            par_bit_q   <= 1'b0;
            data_q      <= '0;
            sh_bits_q   <= CNT_W'(MAX_BITS);
            sh_div_q    <= 3'd3;
            cfg_bits_q  <= CNT_W'(MAX_BITS);
            cfg_div_q   <= 3'd3;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sl0_q       <= 1'b1;
            sl1_q       <= 1'b1;
            busy_q      <= 1'b0;
            wr_ready_q  <= 1'b1;
            word_done_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            par_done_q  <= par_done_d;
            par_bit_q   <= par_bit_d;
            data_q      <= data_d;
            sh_bits_q   <= sh_bits_d;
            sh_div_q    <= sh_div_d;
            cfg_bits_q  <= cfg_bits_d;
            cfg_div_q   <= cfg_div_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sl0_q       <= sl0_d;
            sl1_q       <= sl1_d;
            busy_q      <= busy_d;
            wr_ready_q  <= wr_ready_d;
            word_done_q <= word_done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign sl0        = sl0_q;
    assign sl1        = sl1_q;
    assign busy       = busy_q;
    assign wr_ready   = wr_ready_q;
    assign fifo_level = count_q;
    assign word_done  = word_done_q;
    assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_sl_tx_fifo.sv
// Bench for sl_tx_fifo: directed and random words checked cycle by cycle against a word-queue
// model that expands each popped word into its expected per-clock line values.
module tb_sl_tx_fifo;
    localparam int MAX_BITS   = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(MAX_BITS + 1);
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
`ifdef SL_TX_PARITY_SEL_EN
    localparam bit PAR_SEL = 1'b1;
`else
    localparam bit PAR_SEL = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic [MAX_BITS-1:0] wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [CNT_W-1:0]    cfg_bits;
    logic [2:0]          cfg_div;
    logic                cfg_parity_even;
    logic                cfg_we;
    logic                cfg_err;
    logic                sl0, sl1, busy, word_done;
    logic [LVL_W-1:0]    fifo_level;

    sl_tx_fifo #(.MAX_BITS(MAX_BITS), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .cfg_bits(cfg_bits), .cfg_div(cfg_div), .cfg_parity_even(cfg_parity_even),
        .cfg_we(cfg_we), .cfg_err(cfg_err), .sl0(sl0), .sl1(sl1), .busy(busy),
        .fifo_level(fifo_level), .word_done(word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [1:0]          exp_q[$];
    logic [MAX_BITS-1:0] pend_q[$];
    int m_bits, m_div;
    bit m_even, m_busy, last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit legal(input int bits, input int div);
        return (bits % 2 == 0) && (bits >= 8) && (bits <= MAX_BITS) && (div <= 4);
    endfunction

    task automatic model_reset();
        pend_q.delete();
        exp_q.delete();
        m_bits = MAX_BITS;
        m_div  = 3;
        m_even = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic push_phase(input logic [1:0] v);
        repeat (2 << m_div) exp_q.push_back(v);
    endtask

    // {sl0,sl1}: high 11, one 10, zero 01, stop 00.
    task automatic build_word(input logic [MAX_BITS-1:0] d);
        bit x = 1'b0;
        bit pbit;
        for (int i = 0; i < m_bits; i++) x ^= d[i];
        pbit = m_even ? x : !x;
        push_phase(2'b11);
        for (int i = 0; i < m_bits; i++) begin
            push_phase(d[i] ? 2'b10 : 2'b01);
            push_phase(2'b11);
        end
        push_phase(pbit ? 2'b10 : 2'b01);
        push_phase(2'b11);
        push_phase(2'b00);
        push_phase(2'b11);
    endtask

    // One clock: advance the model with the inputs now driven, then compare all outputs.
    task automatic step();
        logic [1:0] line = 2'b11;
        bit exp_done = 1'b0;
        bit exp_err  = 1'b0;
        last_acc = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_err  = cfg_we && !legal(int'(cfg_bits), int'(cfg_div));
            last_acc = wr_valid && (pend_q.size() < FIFO_DEPTH);
            if (exp_q.size() == 0) begin
                exp_done = m_busy;
                if (pend_q.size() != 0) build_word(pend_q.pop_front());
            end
            if (last_acc) pend_q.push_back(wr_data);
            if (cfg_we && !exp_err) begin
                m_bits = int'(cfg_bits);
                m_div  = int'(cfg_div);
                m_even = PAR_SEL && cfg_parity_even;
            end
            m_busy = (exp_q.size() != 0);
            if (m_busy) line = exp_q.pop_front();
        end
        @(posedge clk);
        #1;
        if (word_done === 1'b1) done_count++;
        check("sl0", 32'(sl0), 32'(line[1]));
        check("sl1", 32'(sl1), 32'(line[0]));
        check("busy", 32'(busy), 32'(m_busy));
        check("fifo_level", 32'(fifo_level), 32'(pend_q.size()));
        check("wr_ready", 32'(wr_ready), 32'(pend_q.size() != FIFO_DEPTH));
        check("word_done", 32'(word_done), 32'(exp_done));
        check("cfg_err", 32'(cfg_err), 32'(exp_err));
    endtask

    task automatic cfg_write(input int bits, input int div, input bit par);
        cfg_bits        = CNT_W'(bits);
        cfg_div         = 3'(div);
        cfg_parity_even = par;
        cfg_we          = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic write_word(input logic [MAX_BITS-1:0] d);
        int n = 0;
        wr_data  = d;
        wr_valid = 1'b1;
        step();
        while (!last_acc && n < 3000) begin
            step();
            n++;
        end
        wr_valid = 1'b0;
        check("write_accept", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 20000) begin
            step();
            n++;
        end
        check("drain_done", 32'(exp_q.size() + pend_q.size()), 32'd0);
        step();
        step();
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0;
        cfg_bits = '0; cfg_div = '0; cfg_parity_even = 1'b0; cfg_we = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset configuration: 32 bits, 16-clock phases, odd parity.
        write_word($urandom);
        drain();

        // Single 0xA5 word, then same word with even parity requested, then upper bits set.
        cfg_write(8, 0, 1'b0);
        d0 = done_count;
        write_word(32'h0000_00A5);
        drain();
        check("single_done_pulses", 32'(done_count - d0), 32'd1);
        cfg_write(8, 0, 1'b1);
        write_word(32'h0000_00A5);
        drain();
        cfg_write(8, 0, 1'b0);
        write_word(32'hFFFF_FF5A);
        drain();

        // Back-to-back words.
        d0 = done_count;
        write_word(32'h1);
        write_word(32'h2);
        write_word(32'h3);
        drain();
        check("b2b_done_pulses", 32'(done_count - d0), 32'd3);

        // FIFO full while the line is busy; fifth word waits for the next pop.
        write_word(32'h10);
        repeat (3) step();
        for (int i = 0; i < 4; i++) write_word($urandom);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'(FIFO_DEPTH));
        write_word($urandom);
        drain();

        // Illegal writes keep 8 bits / 2-clock phases.
        cfg_write(7, 0, 1'b0);
        cfg_write(6, 0, 1'b0);
        cfg_write(8, 5, 1'b0);
        write_word($urandom);
        drain();

        // Divider change mid-word only affects the next word.
        write_word($urandom);
        write_word($urandom);
        repeat (10) step();
        cfg_write(8, 1, 1'b0);
        drain();

        // Reset mid-word with a queued word.
        cfg_write(8, 0, 1'b0);
        write_word($urandom);
        write_word($urandom);
        write_word($urandom);
        repeat (15) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        cfg_write(10, 0, 1'b1);
        write_word($urandom);
        drain();

        // Random configurations, words and gaps.
        for (int it = 0; it < 8; it++) begin
            int nw;
            cfg_write($urandom_range(0, 63), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            cfg_write(2 * $urandom_range(4, MAX_BITS / 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)));
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                write_word($urandom);
                repeat ($urandom_range(0, 2)) step();
            end
            if ($urandom_range(0, 1) == 1)
                cfg_write(2 * $urandom_range(4, MAX_BITS / 2), $urandom_range(0, 2),
                          1'($urandom_range(0, 1)));
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
